adder_tree_loader: RTL

ADDER_TREE_LOADER -- requirements
Module: adder_tree_loader

---
 rtl/adder_tree_pkg.sv | 17 +
 rtl/adder_tree_loader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/adder_tree_pkg.sv
// Shared types and default sizing for the adder-tree frame loader.
// Contents:
//   DATA_W_DEF - default width of one sample word
//   DATA_N_DEF - default number of words per frame
//   state_t    - loader FSM states (FILL, HOLD, DROP)
package adder_tree_pkg;

  localparam int unsigned DATA_W_DEF = 13;
  localparam int unsigned DATA_N_DEF = 11;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } state_t;

endpackage

// File: rtl/adder_tree_loader.sv
// Collects a stream of sample words into one packed frame for a signed adder
// tree. Short frames are zero padded, long frames are truncated and their
// tail dropped; both are flagged with m_err alongside the frame.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   s_valid/s_ready     - input word handshake
//   s_data, s_last      - input word and end-of-frame marker
//   m_valid/m_ready     - output frame handshake
//   m_data              - packed frame, word 0 is the first accepted word
//   m_err               - frame length error, qualified by m_valid
module adder_tree_loader
  import adder_tree_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DATA_N = DATA_N_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_W-1:0]              s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [0:DATA_N-1][DATA_W-1:0]  m_data,
  output logic                           m_err
);

  localparam int unsigned IDX_W = (DATA_N > 1) ? $clog2(DATA_N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_N - 1);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [IDX_W-1:0]                r_idx;
  logic [0:DATA_N-1][DATA_W-1:0]   r_buf;
  logic [0:DATA_N-1][DATA_W-1:0]   w_frame;
  logic                            r_drop_pend;
  logic                            r_hold_err;

  logic w_fill_acc;
  logic w_drop_acc;
  logic w_at_end;
  logic w_done;
  logic w_long;
  logic w_err_now;
  logic w_out_free;
  logic w_load_fill;
  logic w_load_hold;
  logic w_hold_enter;

  // Acceptance is decoded from the state register directly (s_ready mirrors it).
  assign w_fill_acc = s_valid && (r_state == FILL);
  assign w_drop_acc = s_valid && (r_state == DROP);
  assign w_at_end   = (r_idx == LAST_IDX);
  assign w_done     = w_fill_acc && (w_at_end || s_last);
  assign w_long     = w_at_end && !s_last;
  assign w_err_now  = !(w_at_end && s_last);
  assign w_out_free = !m_valid || m_ready;

  // Completed frame: stored words, the word arriving now, zeros after it.
  always_comb begin
    w_frame = '0;
    for (int unsigned i = 0; i < DATA_N; i++) begin
      if (IDX_W'(i) < r_idx) begin
        w_frame[i] = r_buf[i];
      end else if (IDX_W'(i) == r_idx) begin
        w_frame[i] = s_data;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL: begin
        if (w_done) begin
          if (!w_out_free) begin
            w_state_nxt = HOLD;
          end else if (w_long) begin
            w_state_nxt = DROP;
          end
        end
      end
      HOLD: begin
        if (w_out_free) begin
          w_state_nxt = r_drop_pend ? DROP : FILL;
        end
      end
      DROP: begin
        if (w_drop_acc && s_last) begin
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Output / control decode
  always_comb begin
    s_ready      = 1'b1;
    w_load_fill  = 1'b0;
    w_load_hold  = 1'b0;
    w_hold_enter = 1'b0;
    case (r_state)
      FILL: begin
        w_load_fill  = w_done && w_out_free;
        w_hold_enter = w_done && !w_out_free;
      end
      HOLD: begin
        s_ready     = 1'b0;
        w_load_hold = w_out_free;
      end
      default: ;
    endcase
  end

  // Fill buffer, word index and pending-frame attributes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_buf       <= '0;
      r_drop_pend <= 1'b0;
      r_hold_err  <= 1'b0;
    end else begin
      if (w_fill_acc) begin
        r_idx <= w_done ? '0 : r_idx + 1'b1;
      end
      // A frame parked in HOLD is captured whole so later slots read as zero.
      if (w_hold_enter) begin
        r_buf       <= w_frame;
        r_drop_pend <= w_long;
        r_hold_err  <= w_err_now;
      end else if (w_fill_acc) begin
        r_buf[r_idx] <= s_data;
      end
      if (w_load_hold) begin
        r_drop_pend <= 1'b0;
      end
    end
  end

  // Output frame register; a load on a transfer cycle keeps m_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= 1'b0;
    end else if (w_load_fill) begin
      m_valid <= 1'b1;
      m_data  <= w_frame;
      m_err   <= w_err_now;
    end else if (w_load_hold) begin
      m_valid <= 1'b1;
      m_data  <= r_buf;
      m_err   <= r_hold_err;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
